// File: rtl/bsg_fsb_test_node_responder.sv
// FSB test-node client: checks stimulus packets from a master and answers each good one.
// Optional sequence checking is enabled by defining BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN.
module bsg_fsb_test_node_responder #(
    parameter int unsigned ring_width_p  = 80,
    parameter int unsigned master_id_p   = 0,
    parameter int unsigned client_id_p   = 2,
    parameter int unsigned num_packets_p = 16,
    parameter int unsigned seq_width_p   = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    en_i,
    output logic                    done_o,
    output logic                    error_o,
    input  logic                    v_i,
    input  logic [ring_width_p-1:0] data_i,
    output logic                    ready_o,
    output logic                    v_o,
    output logic [ring_width_p-1:0] data_o,
    input  logic                    yumi_i
);

    localparam int unsigned payload_w_lp = ring_width_p - 5;
    localparam int unsigned cnt_w_lp     = $clog2(num_packets_p + 1);

    typedef enum logic [1:0] {
        e_idle,
        e_rx,
        e_tx,
        e_done
    } state_e;

    state_e                    state_r, state_n;
    logic [ring_width_p-1:0]   resp_r, resp_n;
    logic [cnt_w_lp-1:0]       cnt_r, cnt_n;
    logic                      err_r, err_n;

    logic [3:0]                rx_dest;
    logic                      rx_cmd;
    logic [payload_w_lp-1:0]   rx_payload;
    logic                      rx_good;

    assign rx_dest    = data_i[ring_width_p-1 -: 4];
    assign rx_cmd     = data_i[ring_width_p-5];
    assign rx_payload = data_i[payload_w_lp-1:0];
    assign rx_good    = (rx_dest == 4'(client_id_p)) && !rx_cmd;

`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
    logic [seq_width_p-1:0]    seq_r, seq_n;
    logic [seq_width_p-1:0]    rx_seq;

    assign rx_seq = rx_payload[seq_width_p-1:0];
`endif

    // Next-state, response capture, sent counter and sticky error
    always_comb begin
        state_n = state_r;
        resp_n  = resp_r;
        cnt_n   = cnt_r;
        err_n   = err_r;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
        seq_n   = seq_r;
`endif
        case (state_r)
            e_idle: begin
                if (en_i) state_n = e_rx;
            end
            e_rx: begin
                if (v_i && en_i) begin
                    if (rx_good) begin
                        resp_n  = {4'(master_id_p), 1'b0, rx_payload + payload_w_lp'(1)};
                        state_n = e_tx;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
                        if (rx_seq != seq_r) err_n = 1'b1;
                        seq_n = rx_seq + seq_width_p'(1);
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            e_tx: begin
                if (yumi_i) begin
                    cnt_n   = cnt_r + cnt_w_lp'(1);
                    state_n = (cnt_n == cnt_w_lp'(num_packets_p)) ? e_done : e_rx;
                end
            end
            e_done: begin
                state_n = e_done;
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_idle;
            resp_r  <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
            seq_r   <= '0;
`endif
        end else begin
            state_r <= state_n;
            resp_r  <= resp_n;
            cnt_r   <= cnt_n;
            err_r   <= err_n;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
            seq_r   <= seq_n;
`endif
        end
    end

    // Outputs decode registered state; ready also follows en_i while receiving
    assign ready_o = (state_r == e_rx) && en_i;
    assign v_o     = (state_r == e_tx);
    assign done_o  = (state_r == e_done);
    assign data_o  = resp_r;
    assign error_o = err_r;

endmodule

// File: tb/tb_bsg_fsb_test_node_responder.sv
// Randomized self-checking bench for bsg_fsb_test_node_responder against a transaction-level model.
module tb_bsg_fsb_test_node_responder;

    localparam int unsigned ring_w_lp = 80;
    localparam int unsigned pay_w_lp  = 75;
    localparam int unsigned n_pkts_lp = 4;

    logic                 clk_i = 1'b0;
    logic                 reset_n_i = 1'b1;
    logic                 en_i = 1'b0;
    logic                 done_o;
    logic                 error_o;
    logic                 v_i = 1'b0;
    logic [ring_w_lp-1:0] data_i = '0;
    logic                 ready_o;
    logic                 v_o;
    logic [ring_w_lp-1:0] data_o;
    logic                 yumi_i = 1'b0;

    int checks = 0;
    int failures = 0;

    // Model: pending responses, responses delivered, enabled-since-reset, sticky error
    logic [ring_w_lp-1:0] exp_q[$];
    int                   m_sent = 0;
    bit                   m_active = 1'b0;
    bit                   m_err = 1'b0;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
    logic [7:0]           m_seq = 8'd0;
`endif

    bsg_fsb_test_node_responder #(
        .ring_width_p (80),
        .master_id_p  (0),
        .client_id_p  (2),
        .num_packets_p(4),
        .seq_width_p  (8)
    ) dut (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .en_i     (en_i),
        .done_o   (done_o),
        .error_o  (error_o),
        .v_i      (v_i),
        .data_i   (data_i),
        .ready_o  (ready_o),
        .v_o      (v_o),
        .data_o   (data_o),
        .yumi_i   (yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Consuming a response that is not offered is illegal
    always @(posedge clk_i) begin
        assert (!(reset_n_i && yumi_i && !v_o))
            else $error("FAIL yumi_without_v_o got yumi_i=1 v_o=0 required v_o=1");
    end

    task automatic chk(input string tag, input logic [ring_w_lp-1:0] got, input logic [ring_w_lp-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        en_i      = 1'b0;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        data_i    = '0;
        #1;
        chk("rst_ready", 80'(ready_o), 80'(0));
        chk("rst_v_o",   80'(v_o),     80'(0));
        chk("rst_done",  80'(done_o),  80'(0));
        chk("rst_error", 80'(error_o), 80'(0));
        chk("rst_data",  data_o,       80'(0));
        exp_q.delete();
        m_sent   = 0;
        m_active = 1'b0;
        m_err    = 1'b0;
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
        m_seq    = 8'd0;
`endif
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // One clock: drive inputs, compare outputs with the model, then advance the model
    task automatic step(input bit v, input logic [3:0] dest, input logic cmd,
                        input logic [pay_w_lp-1:0] p, input bit en, input bit yumi_want);
        bit pend, done, exp_rdy;
        pend    = (exp_q.size() != 0);
        done    = (m_sent == n_pkts_lp);
        exp_rdy = m_active && !pend && !done && en;
        en_i    = en;
        v_i     = v;
        data_i  = {dest, cmd, p};
        yumi_i  = yumi_want && pend;
        #1;
        chk("ready_o", 80'(ready_o), 80'(exp_rdy));
        chk("v_o",     80'(v_o),     80'(pend));
        chk("done_o",  80'(done_o),  80'(done));
        chk("error_o", 80'(error_o), 80'(m_err));
        if (pend) chk("data_o", data_o, exp_q[0]);
        if (yumi_i) begin
            void'(exp_q.pop_front());
            m_sent++;
        end else if (v && exp_rdy) begin
            if (dest == 4'd2 && cmd == 1'b0) begin
                exp_q.push_back({4'd0, 1'b0, p + 75'd1});
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
                if (p[7:0] != m_seq) m_err = 1'b1;
                m_seq = p[7:0] + 8'd1;
`endif
            end else begin
                m_err = 1'b1;
            end
        end
        if (en) m_active = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input bit en);
        step(1'b0, 4'd0, 1'b0, '0, en, 1'b0);
    endtask

    // Send one good packet and consume its response in the next cycle
    task automatic good_pkt(input logic [pay_w_lp-1:0] p);
        step(1'b1, 4'd2, 1'b0, p, 1'b1, 1'b0);
        step(1'b0, 4'd0, 1'b0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [pay_w_lp-1:0] rp;
        logic [pay_w_lp-1:0] ones;
        ones = '1;
        #2;
        do_reset();

        // Basic loopback
        idle(1'b1);
        for (int i = 0; i < 4; i++) good_pkt(75'(i));
        idle(1'b1);
        idle(1'b1);

        // Backpressure, bad dest/cmd, payload wrap, en low
        do_reset();
        idle(1'b0);
        idle(1'b1);
        step(1'b1, 4'd2, 1'b0, 75'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 4'd2, 1'b0, 75'(i + 7), 1'b1, 1'b0);
        idle(1'b1);
        step(1'b0, 4'd0, 1'b0, '0, 1'b1, 1'b1);
        step(1'b1, 4'd3, 1'b0, 75'd1, 1'b1, 1'b0);
        step(1'b1, 4'd2, 1'b1, 75'd1, 1'b1, 1'b0);
        good_pkt(75'd1);
        good_pkt(ones);
        step(1'b1, 4'd2, 1'b0, 75'd5, 1'b0, 1'b0);
        step(1'b1, 4'd2, 1'b0, 75'd5, 1'b0, 1'b0);
        good_pkt(75'd3);
        idle(1'b1);

        // Sequence gap 0,1,3,4
        do_reset();
        idle(1'b1);
        good_pkt(75'd0);
        good_pkt(75'd1);
        good_pkt(75'd3);
        good_pkt(75'd4);
        idle(1'b1);

        // Asynchronous reset while a response is held, then a fresh run
        do_reset();
        idle(1'b1);
        step(1'b1, 4'd2, 1'b0, 75'd9, 1'b1, 1'b0);
        #2;
        do_reset();
        idle(1'b1);
        for (int i = 0; i < 4; i++) good_pkt(75'(i));
        idle(1'b1);

        // Randomized traffic
        for (int run = 0; run < 6; run++) begin
            do_reset();
            for (int c = 0; c < 150; c++) begin
                rp = 75'({$urandom(), $urandom(), $urandom()});
`ifdef BSG_TEST_NODE_RESPONDER_SEQ_CHECK_EN
                if ($urandom_range(0, 1) == 1) rp[7:0] = m_seq;
`endif
                step($urandom_range(0, 99) < 60,
                     ($urandom_range(0, 9) == 0) ? 4'd3 : 4'd2,
                     ($urandom_range(0, 9) == 0),
                     rp,
                     $urandom_range(0, 9) < 8,
                     $urandom_range(0, 1) == 1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
